// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encodings
// and the counter-width helper.
package bsa_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

  // Width of a counter that must hold 0..wl inclusive.
  function automatic int cnt_w(input int wl);
    return $clog2(wl + 1);
  endfunction

endpackage

// File: rtl/bsa_if.sv
// Operand/result handshake bundle between a parallel requester (master) and
// the bit-serial add controller (slave).
interface bsa_if #(
  parameter int WL = 4
);

  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] a;
  logic [WL-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [WL:0]   sum;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum
  );

endinterface

// File: rtl/bsa_serial_slice.sv
// One-bit full adder with its carry flop. The carry is cleared on load so a
// new operand pair always starts with carry-in zero.
module bsa_serial_slice (
  input  logic clk,
  input  logic rst_n,
  input  logic load_clr,
  input  logic en,
  input  logic a_bit,
  input  logic b_bit,
  output logic s
);

  logic carry_q;
  logic carry_d;

  assign s = a_bit ^ b_bit ^ carry_q;

  // Next carry: clear on load, majority of the three inputs while shifting.
  always_comb begin
    carry_d = carry_q;
    if (load_clr) begin
      carry_d = 1'b0;
    end else if (en) begin
      carry_d = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
    end
  end

  // Carry register.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its inputs, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/bsa_controller.sv
// Sequencer for a WL-bit bit-serial adder. Accepts an operand pair, shifts it
// LSB-first through a full-adder slice for WL+1 cycles, assembles the serial
// sum into a WL+1 bit result and offers it on a valid/ready output.
module bsa_controller
  import bsa_pkg::*;
#(
  parameter int WL = 4
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     clr,
  bsa_if.slave     bus,
  output logic     busy,
  output logic     sbit
);

  localparam int CW = cnt_w(WL);

  state_t        state_q, state_d;
  logic [WL-1:0] a_sr_q, a_sr_d;
  logic [WL-1:0] b_sr_q, b_sr_d;
  logic [WL:0]   sum_q, sum_d;
  logic [CW-1:0] count_q, count_d;

  logic load;
  logic shift_en;
  logic s;

  bsa_serial_slice u_slice (
    .clk      (CLK),
    .rst_n    (RST),
    .load_clr (load | clr),
    .en       (shift_en),
    .a_bit    (a_sr_q[0]),
    .b_bit    (b_sr_q[0]),
    .s        (s)
  );

  // FSM and datapath next-state: clr overrides every other transition.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_d    = sum_q;
    count_d  = count_q;
    load     = 1'b0;
    shift_en = 1'b0;

    if (clr) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr_d  = bus.a;
            b_sr_d  = bus.b;
            count_d = '0;
            load    = 1'b1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          shift_en = 1'b1;
          // Zero fill means the last shift adds 0+0+carry, so the top sum
          // bit is the final carry and the result cannot overflow.
          a_sr_d   = {1'b0, a_sr_q[WL-1:1]};
          b_sr_d   = {1'b0, b_sr_q[WL-1:1]};
          sum_d    = {s, sum_q[WL:1]};
          if (count_q == CW'(WL)) begin
            state_d = DONE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  // NOTE: the operand and result shift registers are reset as well, because
  // sum is directly visible on the port and must read zero out of reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign busy          = (state_q != IDLE);
  assign sbit          = (state_q == SHIFT) ? s : 1'b0;

endmodule

// File: tb/tb_bsa_controller.sv
// Directed bench for bsa_controller at WL=4.
module tb_bsa_controller;

  localparam int WL = 4;

  logic CLK = 1'b0;
  logic RST;
  logic clr;
  logic busy;
  logic sbit;

  int checks   = 0;
  int failures = 0;

  bsa_if #(.WL(WL)) bus ();

  bsa_controller #(.WL(WL)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (clr),
    .bus  (bus),
    .busy (busy),
    .sbit (sbit)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then settled.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete add from IDLE; returns the sum and edges from accept to out_valid.
  task automatic do_add(input logic [WL-1:0] av, input logic [WL-1:0] bv,
                        output logic [WL:0] s, output int lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    s = bus.sum;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  logic [WL:0] res;
  int          lat;
  logic [4:0]  exp_sbit;
  logic [WL:0] q[$];
  logic [WL:0] exp_sum;
  logic [WL-1:0] ra, rb;
  int          sent, rcvd;
  logic        accepted;

  initial begin
    RST           = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    #3;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sbit", sbit, 0);
    check("rst_sum", bus.sum, 0);
    tick();
    RST = 1'b1;
    tick();

    // 9+7: carry ripples through every bit, serial sum 0,0,0,0,1.
    exp_sbit = 5'b10000;
    bus.a = 4'd9;
    bus.b = 4'd7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = 4'd0;
    bus.b = 4'd3;
    check("accept_busy", busy, 1);
    check("accept_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("sbit_%0d", i), sbit, exp_sbit[i]);
      check($sformatf("shift_out_valid_%0d", i), bus.out_valid, 0);
      check($sformatf("shift_in_ready_%0d", i), bus.in_ready, 0);
      tick();
    end
    check("done_out_valid", bus.out_valid, 1);
    check("done_sum_9_7", bus.sum, 16);
    check("done_sbit", sbit, 0);

    // Stall in DONE with in_valid high; result must hold and nothing is accepted.
    bus.in_valid = 1'b1;
    bus.a = 4'd1;
    bus.b = 4'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_sum", bus.sum, 16);
      check("stall_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check("release_busy", busy, 0);
    check("release_in_ready", bus.in_ready, 1);
    check("release_out_valid", bus.out_valid, 0);
    tick();
    check("idle_stays_idle", busy, 0);

    // Boundary operands.
    do_add(4'd15, 4'd15, res, lat);
    check("sum_15_15", res, 30);
    check("lat_15_15", lat, 5);
    do_add(4'd0, 4'd0, res, lat);
    check("sum_0_0", res, 0);
    check("lat_0_0", lat, 5);

    // clr on the third SHIFT edge aborts the add.
    bus.a = 4'd5;
    bus.b = 4'd6;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_in_ready", bus.in_ready, 1);
    check("clr_out_valid", bus.out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("clr_no_result", bus.out_valid, 0);
    end
    do_add(4'd3, 4'd4, res, lat);
    check("sum_3_4", res, 7);

    // clr in DONE drops the pending result.
    bus.a = 4'd2;
    bus.b = 4'd2;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_clr_done", bus.out_valid, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_done_out_valid", bus.out_valid, 0);
    check("clr_done_busy", busy, 0);

    // Asynchronous reset mid-SHIFT.
    bus.a = 4'd11;
    bus.b = 4'd13;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_sbit", sbit, 0);
    check("arst_sum", bus.sum, 0);
    tick();
    RST = 1'b1;
    tick();
    do_add(4'd1, 4'd1, res, lat);
    check("sum_1_1", res, 2);

    // Back-to-back random pairs with random consumer stalls.
    sent = 0;
    rcvd = 0;
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 5000 && rcvd < 100; cyc++) begin
      accepted = 1'b0;
      if (sent < 100 && !bus.in_valid) begin
        ra = WL'($urandom);
        rb = WL'($urandom);
        bus.a = ra;
        bus.b = rb;
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({1'b0, ra} + {1'b0, rb});
        sent++;
        accepted = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        exp_sum = (q.size() != 0) ? q.pop_front() : 'x;
        check("b2b_sum", bus.sum, exp_sum);
        rcvd++;
      end
      tick();
      if (accepted) begin
        bus.in_valid = 1'b0;
        bus.a = WL'($urandom);
        bus.b = WL'($urandom);
      end
    end
    bus.out_ready = 1'b0;
    check("b2b_received", rcvd, 100);
    check("b2b_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
